// File: rtl/inv_share_arb_pkg.sv
// rtl/inv_share_arb_pkg.sv - shared constants and helpers for the negation arbiter
package inv_share_arb_pkg;

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] NEG_OVF_VAL = 16'h8000;

   // Requester index width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/inv_converter_16.sv
// rtl/inv_converter_16.sv - 16-bit two's-complement negation datapath
module inv_converter_16 (
   input  logic [15:0] x,
   output logic [15:0] y
);

   assign y = ~x + 16'd1;

endmodule

// File: rtl/inv_share_arb.sv
// rtl/inv_share_arb.sv - round-robin arbiter sharing one negator between requesters
module inv_share_arb
   import inv_share_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [DATA_W*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_data_o,
   output logic [ID_W-1:0]           rsp_id_o,
   output logic                      rsp_ovf_o,
   input  logic                      rsp_ready_i
);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   scan_idx;
   logic              grant_valid;
   logic              can_accept;
   logic              accept;
   logic [DATA_W-1:0] operand;
   logic [DATA_W-1:0] negated;
   logic [ID_W-1:0]   ptr_next;

   // First valid request at or after rr_ptr, wrapping around.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!grant_valid && req_valid_i[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   assign can_accept = ~rsp_valid_o | rsp_ready_i;
   assign accept     = grant_valid & can_accept & ~sys_rst;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[grant_idx] = 1'b1;
   end

   always_comb begin
      operand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) operand = req_data_i[i*DATA_W +: DATA_W];
      end
   end

   inv_converter_16 u_neg (
      .x (operand),
      .y (negated)
   );

   assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_id_o    <= '0;
         rsp_ovf_o   <= 1'b0;
         rr_ptr      <= '0;
      end else if (accept) begin
         rsp_valid_o <= 1'b1;
         rsp_data_o  <= negated;
         rsp_id_o    <= grant_idx;
         rsp_ovf_o   <= (operand == NEG_OVF_VAL);
         rr_ptr      <= ptr_next;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inv_share_arb.sv
// tb/tb_inv_share_arb.sv - self-checking bench for inv_share_arb
module tb_inv_share_arb;

   localparam int N = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b0;
   logic [N-1:0]  req_valid_i = '0;
   logic [16*N-1:0] req_data_i = '0;
   logic [N-1:0]  req_ready_o;
   logic          rsp_valid_o;
   logic [15:0]   rsp_data_o;
   logic [1:0]    rsp_id_o;
   logic          rsp_ovf_o;
   logic          rsp_ready_i = 1'b1;

   int checks = 0;
   int errors = 0;

   inv_share_arb #(.NUM_REQ(N), .ID_W(2)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_id_o    (rsp_id_o),
      .rsp_ovf_o   (rsp_ovf_o),
      .rsp_ready_i (rsp_ready_i)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [15:0] v);
      req_data_i[k*16 +: 16] = v;
   endtask

   task automatic do_reset();
      req_valid_i = '0;
      rsp_ready_i = 1'b1;
      sys_rst = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
   endtask

   function automatic logic [15:0] neg_ref(input logic [15:0] x);
      return 16'(17'h10000 - {1'b0, x});
   endfunction

   task automatic test_reset();
      req_valid_i = '1;
      for (int k = 0; k < N; k++) set_data(k, 16'(k + 7));
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (req_ready_o !== 4'b0000) begin
         errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o);
      end
      tick();
      tick();
      checks++;
      if (rsp_valid_o !== 1'b0 || rsp_data_o !== 16'h0000) begin
         errors++; $display("FAIL reset_out got valid=%b data=%h exp valid=0 data=0000", rsp_valid_o, rsp_data_o);
      end
      sys_rst = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (req_ready_o !== 4'b0001) begin
         errors++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready_o);
      end
      tick();
      do_reset();
   endtask

   task automatic test_single();
      req_valid_i = 4'b0100;
      set_data(2, 16'h0005);
      @(negedge sys_clk);
      checks++;
      if (req_ready_o !== 4'b0100) begin
         errors++; $display("FAIL single_ready got=%b exp=0100", req_ready_o);
      end
      tick();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'hFFFB || rsp_id_o !== 2'd2 || rsp_ovf_o !== 1'b0) begin
         errors++; $display("FAIL single_5 got v=%b d=%h id=%0d ovf=%b exp v=1 d=fffb id=2 ovf=0",
                            rsp_valid_o, rsp_data_o, rsp_id_o, rsp_ovf_o);
      end
      set_data(2, 16'h0000);
      tick();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'h0000 || rsp_id_o !== 2'd2) begin
         errors++; $display("FAIL single_0 got v=%b d=%h id=%0d exp v=1 d=0000 id=2", rsp_valid_o, rsp_data_o, rsp_id_o);
      end
      req_valid_i = '0;
      tick();
      checks++;
      if (rsp_valid_o !== 1'b0 || rsp_data_o !== 16'h0000) begin
         errors++; $display("FAIL single_drain got v=%b d=%h exp v=0 d=0000", rsp_valid_o, rsp_data_o);
      end
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [15:0] exp_d;
      logic [3:0]  exp_r;
      for (int k = 0; k < N; k++) set_data(k, 16'(k + 1));
      req_valid_i = '1;
      for (int c = 0; c < 5; c++) begin
         exp_r = 4'(1 << (c % N));
         exp_d = 16'hFFFF - 16'(c % N);
         @(negedge sys_clk);
         checks++;
         if (req_ready_o !== exp_r) begin
            errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready_o, exp_r);
         end
         tick();
         checks++;
         if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_d || rsp_id_o !== 2'(c % N)) begin
            errors++; $display("FAIL rr_out[%0d] got v=%b d=%h id=%0d exp v=1 d=%h id=%0d",
                               c, rsp_valid_o, rsp_data_o, rsp_id_o, exp_d, c % N);
         end
      end
      do_reset();
   endtask

   task automatic test_backpressure();
      req_valid_i = 4'b0001;
      set_data(0, 16'h0100);
      tick();
      rsp_ready_i = 1'b0;
      req_valid_i = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         checks++;
         if (req_ready_o !== 4'b0000 || rsp_valid_o !== 1'b1 || rsp_data_o !== 16'hFF00 || rsp_id_o !== 2'd0) begin
            errors++; $display("FAIL stall[%0d] got rdy=%b v=%b d=%h id=%0d exp rdy=0000 v=1 d=ff00 id=0",
                               c, req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o);
         end
         tick();
      end
      rsp_ready_i = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (req_ready_o !== 4'b0010) begin
         errors++; $display("FAIL stall_release got=%b exp=0010", req_ready_o);
      end
      tick();
      checks++;
      if (rsp_id_o !== 2'd1 || rsp_valid_o !== 1'b1) begin
         errors++; $display("FAIL stall_next_id got id=%0d v=%b exp id=1 v=1", rsp_id_o, rsp_valid_o);
      end
      do_reset();
   endtask

   task automatic test_overflow();
      req_valid_i = 4'b0010;
      set_data(1, 16'h8000);
      tick();
      checks++;
      if (rsp_data_o !== 16'h8000 || rsp_ovf_o !== 1'b1) begin
         errors++; $display("FAIL ovf_8000 got d=%h ovf=%b exp d=8000 ovf=1", rsp_data_o, rsp_ovf_o);
      end
      set_data(1, 16'h7FFF);
      tick();
      checks++;
      if (rsp_data_o !== 16'h8001 || rsp_ovf_o !== 1'b0) begin
         errors++; $display("FAIL ovf_7fff got d=%h ovf=%b exp d=8001 ovf=0", rsp_data_o, rsp_ovf_o);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_stall();
      req_valid_i = 4'b0100;
      set_data(2, 16'h1234);
      tick();
      rsp_ready_i = 1'b0;
      req_valid_i = 4'b1010;
      tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      checks++;
      if (rsp_valid_o !== 1'b0) begin
         errors++; $display("FAIL midrst_valid got=%b exp=0", rsp_valid_o);
      end
      @(negedge sys_clk);
      checks++;
      if (req_ready_o !== 4'b0010) begin
         errors++; $display("FAIL midrst_grant got=%b exp=0010", req_ready_o);
      end
      tick();
      do_reset();
   endtask

   task automatic test_random();
      logic        m_valid = 1'b0;
      logic [15:0] m_data  = '0;
      int          m_id    = 0;
      logic        m_ovf   = 1'b0;
      int          m_next  = 0;
      int          g;
      logic [3:0]  exp_r;
      logic [15:0] x;
      for (int c = 0; c < 400; c++) begin
         req_valid_i = 4'($urandom_range(0, 15));
         for (int k = 0; k < N; k++) set_data(k, ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom));
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         sys_rst = ($urandom_range(0, 39) == 0);
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid_i[(m_next + k) % N]) g = (m_next + k) % N;
         end
         if (sys_rst || g < 0 || (m_valid && !rsp_ready_i)) exp_r = '0;
         else exp_r = 4'(1 << g);
         @(negedge sys_clk);
         checks++;
         if (req_ready_o !== exp_r) begin
            errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready_o, exp_r);
         end
         checks++;
         if (rsp_valid_o !== m_valid || (m_valid && (rsp_data_o !== m_data || rsp_id_o !== 2'(m_id) || rsp_ovf_o !== m_ovf))) begin
            errors++; $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d ovf=%b exp v=%b d=%h id=%0d ovf=%b",
                               c, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_ovf_o, m_valid, m_data, m_id, m_ovf);
         end
         if (sys_rst) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ovf = 1'b0; m_next = 0;
         end else if (exp_r != '0) begin
            x = req_data_i[g*16 +: 16];
            m_valid = 1'b1; m_data = neg_ref(x); m_id = g; m_ovf = (x == 16'h8000);
            m_next = (g + 1) % N;
         end else if (rsp_ready_i) begin
            m_valid = 1'b0;
         end
         tick();
      end
      sys_rst = 1'b0;
      do_reset();
   endtask

   initial begin
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inv_share_arb.md
Name: inv_share_arb

Overview:
- Round-robin arbiter that time-shares one inv_converter_16 (two's-complement negation datapath) between NUM_REQ requesters.
- Typical requesters are the Booth radix-4 partial-product generators that need -X / -2X operands.
- Each requester side uses a valid/ready handshake. The negated result is registered in a single-entry output stage tagged with the requester index.
- Throughput is one negation per cycle; latency is 1 cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- sys_clk, input, 1, system clock; all state updates on rising edge.
- sys_rst, input, 1, synchronous active-high reset.
- req_valid_i, input, NUM_REQ, per-requester request valid.
- req_data_i, input, 16*NUM_REQ, per-requester 16-bit two's-complement operand; slice k is bits [16k+15:16k].
- req_ready_o, output, NUM_REQ, per-requester accept strobe; at most one bit high per cycle.
- rsp_valid_o, output, 1, output register holds a result.
- rsp_data_o, output, 16, negated operand (two's complement).
- rsp_id_o, output, ID_W, index of the requester that produced rsp_data_o.
- rsp_ovf_o, output, 1, set when the operand was 16'h8000 (negation not representable).
- rsp_ready_i, input, 1, downstream consumes the result when high together with rsp_valid_o.

Behaviour:
- Reset: synchronous active-high on sys_clk (decided).
  - While sys_rst=1 at a rising edge: rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_ovf_o=0, round-robin pointer rr_ptr=0.
  - req_ready_o is 0 during any cycle in which sys_rst is high.
- can_accept = ~rsp_valid_o | rsp_ready_i. The output stage accepts a new result when it is empty or being drained in the same cycle.
- Grant (combinational):
  - Search indices rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ, for the first asserted req_valid_i bit; that index is g.
  - No valid request means no grant.
- req_ready_o[g] = can_accept & grant_valid. All other bits are 0. The handshake completes when req_valid_i[g] & req_ready_o[g].
- On accept (rising edge):
  - rsp_data_o <= inv_converter_16(req_data_i slice g).
  - rsp_id_o <= g.
  - rsp_ovf_o <= (slice g == 16'h8000).
  - rsp_valid_o <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Drain with no new accept: if rsp_valid_o & rsp_ready_i and no grant, then rsp_valid_o <= 0. Data, id and ovf hold their last values.
- Stall: if rsp_valid_o=1 & rsp_ready_i=0, then rsp_data_o, rsp_id_o and rsp_ovf_o stay stable, all req_ready_o=0, and rr_ptr is unchanged.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and rsp_valid_o stays 1. This gives back-to-back throughput of 1 per cycle.
- rr_ptr advances only on an accepted handshake. An idle cycle or a stall never moves it.
- Fairness: a continuously asserted request is granted within NUM_REQ accepts.
- Latency: operand accepted at edge N appears on rsp_data_o after edge N; one register, no combinational input-to-output path.
- Arithmetic:
  - rsp_data_o = (~x)+1, truncated to 16 bits.
  - 16'h0000 negates to 16'h0000.
  - 16'h8000 negates to 16'h8000 with rsp_ovf_o=1.
- Requester rules: a requester holds req_data_i stable while req_valid_i is high and unaccepted. The arbiter does not check this. Deasserting valid before accept is allowed; that request is simply skipped.
- Reset mid-operation: a pending output result is discarded and rr_ptr returns to 0. A requester that was valid but unaccepted must re-present its request after reset.

Decomposition:
- Shared package holds:
  - constant NEG_OVF_VAL = 16'h8000;
  - the ID_W derivation function (clog2).
- One sub-module: the existing inv_converter_16, instantiated once. Its input comes from a NUM_REQ:1 mux selected by g.
- The round-robin grant logic may optionally be a sub-module, rr_grant (inputs: valid vector, pointer; outputs: one-hot grant and grant_valid).

Test Plan:
- Reset: assert sys_rst for 2 cycles while all requests are valid -> req_ready_o=0, rsp_valid_o=0, rsp_data_o=0. After release, the first grant goes to index 0.
- Single requester: req 2 sends 16'h0005 with rsp_ready_i=1 -> next cycle rsp_data_o=16'hFFFB, rsp_id_o=2, rsp_ovf_o=0. Then send 16'h0000 -> result 16'h0000.
- Round-robin: all 4 valid with operands 1, 2, 3, 4 and rsp_ready_i=1 -> grants on consecutive cycles in order 0, 1, 2, 3, 0. Outputs are FFFF, FFFE, FFFD, FFFC with matching ids and no bubbles.
- Backpressure: rsp_ready_i=0 for 3 cycles with result 16'hFF00 pending -> output holds 16'hFF00 stable, all req_ready_o=0, rr_ptr unchanged. On release, the next grant follows the pending id.
- Overflow/edge: operand 16'h8000 -> rsp_data_o=16'h8000, rsp_ovf_o=1. Operand 16'h7FFF -> 16'h8001, rsp_ovf_o=0.
- Reset mid-stall: rsp_valid_o=1, rr_ptr=3, then a sys_rst pulse -> rsp_valid_o=0 and the next grant goes to the lowest valid index starting from 0.
